// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// The branch table is program-specific and is the only thing expected to change per program.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [8:0] HALT_OP_DFLT = 9'b111_11_11;

    localparam int LUT_N = 4;
    // Entry 2 is -3 in two's complement: the loop-back offset of the multiply demo
    localparam logic [15:0] LUTP [LUT_N] = '{16'd0, 16'd8, 16'hFFFD, 16'd0};

endpackage

// File: rtl/branch_lut.sv
// Branch target table: operand index to 16-bit target or offset.
// Purely combinational; the interpretation (absolute or relative) belongs to the caller.
module branch_lut
    import fetch_pkg::*;
(
    input  logic [1:0]  lut_idx,
    output logic [15:0] target
);

    assign target = LUTP[lut_idx];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: IDLE/RUN/HALT FSM, program counter with
// sequential, absolute and relative next-PC selection, and a saturating RUN cycle counter.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int             PW         = 16,
    parameter int             IW         = 9,
    parameter logic [PW-1:0]  START_ADDR = '0,
    parameter logic [IW-1:0]  HALT_OP    = IW'(HALT_OP_DFLT)
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Start,
    input  logic [IW-1:0]  Inst,
    input  logic           BranchAbs,
    input  logic           BranchRel,
    input  logic           Taken,
    input  logic [1:0]     LutIdx,
    input  logic           Stall,
    output logic [PW-1:0]  PC,
    output logic           Fetch,
    output logic           Done,
    output logic [15:0]    CycleCount
);

    state_t        state;
    logic [15:0]   lut_val;
    logic [PW-1:0] pc_nxt;

    branch_lut u_lut (
        .lut_idx (LutIdx),
        .target  (lut_val)
    );

    // Absolute targets are unsigned; relative offsets are sign-extended to the PC width
    always_comb begin
        pc_nxt = PC + PW'(1);
        if (BranchAbs && Taken)
            pc_nxt = PW'(lut_val);
        else if (BranchRel && Taken)
            pc_nxt = PC + PW'($signed(lut_val));
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            PC         <= START_ADDR;
            CycleCount <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (Start) begin
                        state      <= RUN;
                        PC         <= START_ADDR;
                        CycleCount <= '0;
                    end
                end
                RUN: begin
                    if (CycleCount != 16'hFFFF)
                        CycleCount <= CycleCount + 16'd1;
                    // A stall masks both halt detection and branching
                    if (!Stall) begin
                        if (Inst == HALT_OP)
                            state <= HALT;
                        else
                            PC <= pc_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign Fetch = (state == RUN);
    assign Done  = (state == HALT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the sequencer.
module tb_fetch_ctrl;

    localparam logic [8:0] HALT = 9'b111_11_11;

    logic        Clk = 1'b0;
    logic        Reset, Start, BranchAbs, BranchRel, Taken, Stall;
    logic [8:0]  Inst;
    logic [1:0]  LutIdx;
    logic [15:0] PC, CycleCount;
    logic        Fetch, Done;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: mode 0 = idle, 1 = running, 2 = halted
    int m_mode = 0;
    int m_pc   = 0;
    int m_cnt  = 0;
    int lut [4] = '{0, 8, -3, 0};

    fetch_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Inst       (Inst),
        .BranchAbs  (BranchAbs),
        .BranchRel  (BranchRel),
        .Taken      (Taken),
        .LutIdx     (LutIdx),
        .Stall      (Stall),
        .PC         (PC),
        .Fetch      (Fetch),
        .Done       (Done),
        .CycleCount (CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic quiet();
        Start = 0; Inst = 9'd0; BranchAbs = 0; BranchRel = 0;
        Taken = 0; LutIdx = 2'd0; Stall = 0;
    endtask

    // Advance one edge and step the model with the inputs that edge sees
    task automatic tick();
        @(posedge Clk);
        if (m_mode == 1) begin
            if (m_cnt < 65535) m_cnt++;
            if (!Stall) begin
                if (Inst == HALT)
                    m_mode = 2;
                else if (BranchAbs && Taken)
                    m_pc = lut[LutIdx] & 32'hFFFF;
                else if (BranchRel && Taken)
                    m_pc = (m_pc + lut[LutIdx] + 65536) % 65536;
                else
                    m_pc = (m_pc + 1) % 65536;
            end
        end else if (Start) begin
            m_mode = 1; m_pc = 0; m_cnt = 0;
        end
        #1;
    endtask

    // Return the running sequencer to PC 0 via absolute branch to LUT[0], then walk to n
    task automatic goto_pc(input int n);
        quiet();
        BranchAbs = 1; Taken = 1; LutIdx = 2'd0;
        tick();
        quiet();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        Reset = 1; quiet();
        #2;
        n_cmp++;
        if ({PC, CycleCount, Fetch, Done} !== {16'd0, 16'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL reset_state got pc=%h cnt=%h f=%b d=%b want 0", PC, CycleCount, Fetch, Done);
        end
        #6 Reset = 0;
        tick();
        Start = 1; tick(); Start = 0;
        n_cmp++;
        if ({PC, Fetch, Done, CycleCount} !== {16'd0, 1'b1, 1'b0, 16'd0}) begin
            n_bad++;
            $display("FAIL launch got pc=%h f=%b d=%b cnt=%h want pc=0 f=1", PC, Fetch, Done, CycleCount);
        end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (PC !== 16'd5) begin
            n_bad++;
            $display("FAIL seq_to_5 got %h want 0005", PC);
        end
        // Reset between edges must clear outputs immediately
        #2 Reset = 1;
        #1;
        m_mode = 0; m_pc = 0; m_cnt = 0;
        n_cmp++;
        if ({PC, CycleCount, Fetch, Done} !== {16'd0, 16'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset got pc=%h cnt=%h f=%b d=%b want 0", PC, CycleCount, Fetch, Done);
        end
        #1 Reset = 0;
        Start = 1; tick(); Start = 0;
        n_cmp++;
        if ({PC, Fetch} !== {16'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL relaunch got pc=%h f=%b want pc=0 f=1", PC, Fetch);
        end
    endtask

    task automatic test_rel_loop();
        int exp_pc [17] = '{0,1,2,3,4,5,6,7,4,5,6,7,4,5,6,8,9};
        int pass = 0;
        // Relaunch from scratch so the cycle count starts at zero
        quiet(); Inst = HALT; tick();
        quiet(); Start = 1; tick();
        for (int i = 0; i < 17; i++) begin
            n_cmp++;
            if (PC !== 16'(exp_pc[i])) begin
                n_bad++;
                $display("FAIL loop_pc[%0d] got %h want %h", i, PC, 16'(exp_pc[i]));
            end
            quiet();
            Inst = (m_pc == 9) ? HALT : 9'h012;
            if (m_pc == 6) begin
                pass++;
                BranchAbs = 1; LutIdx = 2'd1; Taken = (pass == 3);
            end
            if (m_pc == 7) begin
                BranchRel = 1; LutIdx = 2'd2; Taken = 1;
            end
            tick();
        end
        quiet();
        n_cmp++;
        if ({Done, Fetch, PC, CycleCount} !== {1'b1, 1'b0, 16'd9, 16'd17}) begin
            n_bad++;
            $display("FAIL loop_halt got d=%b f=%b pc=%h cnt=%0d want d=1 pc=9 cnt=17", Done, Fetch, PC, CycleCount);
        end
    endtask

    task automatic test_abs_branch();
        quiet(); Start = 1; tick();
        goto_pc(6);
        BranchAbs = 1; Taken = 1; LutIdx = 2'd1; tick();
        n_cmp++;
        if (PC !== 16'd8) begin
            n_bad++;
            $display("FAIL abs_taken got %h want 0008", PC);
        end
        goto_pc(6);
        BranchAbs = 1; Taken = 0; LutIdx = 2'd1; tick();
        n_cmp++;
        if (PC !== 16'd7) begin
            n_bad++;
            $display("FAIL abs_not_taken got %h want 0007", PC);
        end
        goto_pc(6);
        BranchAbs = 1; BranchRel = 1; Taken = 1; LutIdx = 2'd1; tick();
        n_cmp++;
        if (PC !== 16'd8) begin
            n_bad++;
            $display("FAIL abs_over_rel got %h want 0008", PC);
        end
    endtask

    task automatic test_stall_halt();
        int c0;
        goto_pc(3);
        c0 = m_cnt;
        Stall = 1;
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if ({PC, CycleCount} !== {16'd3, 16'(c0 + 3)}) begin
            n_bad++;
            $display("FAIL stall_hold got pc=%h cnt=%0d want pc=3 cnt=%0d", PC, CycleCount, c0 + 3);
        end
        Inst = HALT; tick(); tick();
        n_cmp++;
        if ({Done, PC} !== {1'b0, 16'd3}) begin
            n_bad++;
            $display("FAIL stall_masks_halt got d=%b pc=%h want d=0 pc=3", Done, PC);
        end
        Stall = 0; tick();
        n_cmp++;
        if ({Done, Fetch, PC, CycleCount} !== {1'b1, 1'b0, 16'd3, 16'(c0 + 6)}) begin
            n_bad++;
            $display("FAIL halt_after_stall got d=%b f=%b pc=%h cnt=%0d want d=1 pc=3 cnt=%0d", Done, Fetch, PC, CycleCount, c0 + 6);
        end
    endtask

    task automatic test_restart();
        quiet(); Start = 1; tick();
        n_cmp++;
        if ({Done, Fetch, PC, CycleCount} !== {1'b0, 1'b1, 16'd0, 16'd0}) begin
            n_bad++;
            $display("FAIL restart got d=%b f=%b pc=%h cnt=%h want d=0 f=1 pc=0 cnt=0", Done, Fetch, PC, CycleCount);
        end
        quiet(); tick(); tick();
        Start = 1; tick(); Start = 0;
        n_cmp++;
        if ({PC, CycleCount} !== {16'd3, 16'd3}) begin
            n_bad++;
            $display("FAIL start_in_run got pc=%h cnt=%h want 0003/0003", PC, CycleCount);
        end
    endtask

    task automatic test_wrap();
        goto_pc(1);
        BranchRel = 1; Taken = 1; LutIdx = 2'd2; tick();
        n_cmp++;
        if (PC !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL rel_neg got %h want fffe", PC);
        end
        quiet(); tick();
        n_cmp++;
        if (PC !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL seq_to_ffff got %h want ffff", PC);
        end
        tick();
        n_cmp++;
        if (PC !== 16'h0000) begin
            n_bad++;
            $display("FAIL pc_wrap got %h want 0000", PC);
        end
    endtask

    task automatic test_saturate();
        quiet(); Inst = HALT; tick();
        quiet(); Start = 1; tick(); Start = 0;
        for (int i = 1; i <= 65540; i++) begin
            tick();
            if (i == 65535) begin
                n_cmp++;
                if (CycleCount !== 16'hFFFF) begin
                    n_bad++;
                    $display("FAIL cnt_reach_max got %h want ffff", CycleCount);
                end
            end
        end
        n_cmp++;
        if ({CycleCount, PC, Fetch} !== {16'hFFFF, 16'd4, 1'b1}) begin
            n_bad++;
            $display("FAIL cnt_saturate got cnt=%h pc=%h f=%b want ffff/0004/1", CycleCount, PC, Fetch);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 3000; i++) begin
            Start     = ($urandom_range(7) == 0);
            Stall     = ($urandom_range(3) == 0);
            Inst      = ($urandom_range(15) == 0) ? HALT : 9'($urandom_range(511));
            BranchAbs = $urandom_range(1);
            BranchRel = $urandom_range(1);
            Taken     = $urandom_range(1);
            LutIdx    = 2'($urandom_range(3));
            tick();
            n_cmp++;
            if ({PC, CycleCount, Fetch, Done} !==
                {16'(m_pc), 16'(m_cnt), m_mode == 1, m_mode == 2}) begin
                n_bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random[%0d] got pc=%h cnt=%h f=%b d=%b want pc=%h cnt=%h mode=%0d",
                             i, PC, CycleCount, Fetch, Done, 16'(m_pc), 16'(m_cnt), m_mode);
            end
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_rel_loop();
        test_abs_branch();
        test_stall_halt();
        test_restart();
        test_wrap();
        test_saturate();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
